// File: rtl/calib_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// calib_scan_ctrl_if
// Bundles the request/ADC inputs and the position/status outputs of the
// calibration scan sequencer. Clock and reset are not part of the bundle.
//
// Signals:
//   start     scan request (master -> slave)
//   abort     cancel a running scan (master -> slave)
//   adc_valid adc_data carries a fresh conversion this cycle
//   adc_data  12-bit unsigned panel voltage sample
//   pos_H     horizontal servo pulse width (slave -> master)
//   pos_V     vertical servo pulse width (slave -> master)
//   max_V_in  best voltage seen in the most recent axis scan
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse when a full scan completes
//   STAT      3-bit state code
// ---------------------------------------------------------------------------
interface calib_scan_ctrl_if #(
  parameter int unsigned POS_W = 32
) ();

  logic             start;
  logic             abort;
  logic             adc_valid;
  logic [11:0]      adc_data;
  logic [POS_W-1:0] pos_H;
  logic [POS_W-1:0] pos_V;
  logic [11:0]      max_V_in;
  logic             busy;
  logic             done;
  logic [2:0]       STAT;

  // The controlling side: drives requests and ADC samples.
  modport master (
    output start, abort, adc_valid, adc_data,
    input  pos_H, pos_V, max_V_in, busy, done, STAT
  );

  // The sequencer side.
  modport slave (
    input  start, abort, adc_valid, adc_data,
    output pos_H, pos_V, max_V_in, busy, done, STAT
  );

endinterface

// File: rtl/calib_scan_ctrl.sv
// ---------------------------------------------------------------------------
// calib_scan_ctrl
// Calibration scan sequencer for the two-axis solar tracker. A start request
// steps the horizontal servo from POS_MIN in POS_STEP increments up to
// POS_MAX, waiting SETTLE_CYCLES per point and then taking one ADC sample.
// The horizontal axis is parked at the point with the highest voltage
// (earliest point wins ties), then the vertical axis is scanned the same way.
//
// Ports:
//   CLK  system clock
//   RST  asynchronous active-low reset
//   bus  calib_scan_ctrl_if slave modport:
//        start/abort requests, adc_valid/adc_data samples in;
//        pos_H/pos_V servo positions, max_V_in, busy, done, STAT out.
// All outputs are registered.
// ---------------------------------------------------------------------------
module calib_scan_ctrl #(
  parameter int unsigned POS_W         = 32,
  parameter int unsigned POS_MIN       = 50000,
  parameter int unsigned POS_MAX       = 250000,
  parameter int unsigned POS_STEP      = 10000,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  calib_scan_ctrl_if.slave  bus
);

  // State codes double as the STAT output.
  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] H_SETTLE = 3'b001;
  localparam logic [2:0] H_SAMPLE = 3'b010;
  localparam logic [2:0] V_SETTLE = 3'b011;
  localparam logic [2:0] V_SAMPLE = 3'b100;

  localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_STEP = POS_W'(POS_STEP);
  localparam logic [POS_W-1:0] P_MID  = POS_W'((POS_MIN + POS_MAX) / 2);

  // Settle counter runs 0..SETTLE_CYCLES-1 while in a settle state.
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       r_state;
  logic [POS_W-1:0] r_pos_h;
  logic [POS_W-1:0] r_pos_v;
  logic [POS_W-1:0] r_best_h;
  logic [POS_W-1:0] r_best_v;
  logic [11:0]      r_max_v;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state;
  logic [POS_W-1:0] w_pos_h;
  logic [POS_W-1:0] w_pos_v;
  logic [POS_W-1:0] w_best_h;
  logic [POS_W-1:0] w_best_v;
  logic [11:0]      w_max_v;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;

  logic             w_new_max;
  logic [11:0]      w_max_upd;
  logic [POS_W-1:0] w_h_best_upd;
  logic [POS_W-1:0] w_v_best_upd;
  logic [POS_W:0]   w_h_sum;
  logic [POS_W:0]   w_v_sum;
  logic             w_h_last;
  logic             w_v_last;

  // Sample evaluation and end-of-axis detection. The end test uses one extra
  // bit so a position near the top of the POS_W range can never wrap.
  always_comb begin
    w_new_max    = bus.adc_data > r_max_v;
    w_max_upd    = w_new_max ? bus.adc_data : r_max_v;
    w_h_best_upd = w_new_max ? r_pos_h : r_best_h;
    w_v_best_upd = w_new_max ? r_pos_v : r_best_v;
    w_h_sum      = {1'b0, r_pos_h} + {1'b0, P_STEP};
    w_v_sum      = {1'b0, r_pos_v} + {1'b0, P_STEP};
    w_h_last     = w_h_sum > {1'b0, P_MAX};
    w_v_last     = w_v_sum > {1'b0, P_MAX};
  end

  // Next-state logic. abort is checked first in every active state so it
  // wins over a simultaneous adc_valid; positions and max_V_in simply hold.
  always_comb begin
    w_state  = r_state;
    w_pos_h  = r_pos_h;
    w_pos_v  = r_pos_v;
    w_best_h = r_best_h;
    w_best_v = r_best_v;
    w_max_v  = r_max_v;
    w_cnt    = r_cnt;
    w_done   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state  = H_SETTLE;
          w_pos_h  = P_MIN;
          w_max_v  = '0;
          w_best_h = P_MIN;
          w_cnt    = '0;
        end
      end

      H_SETTLE: begin
        if (bus.abort) begin
          w_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state = H_SAMPLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      H_SAMPLE: begin
        if (bus.abort) begin
          w_state = IDLE;
        end else if (bus.adc_valid) begin
          w_cnt = '0;
          if (w_h_last) begin
            // Park horizontal at its best point and start the vertical scan.
            w_pos_h  = w_h_best_upd;
            w_best_h = w_h_best_upd;
            w_pos_v  = P_MIN;
            w_best_v = P_MIN;
            w_max_v  = '0;
            w_state  = V_SETTLE;
          end else begin
            w_pos_h  = w_h_sum[POS_W-1:0];
            w_best_h = w_h_best_upd;
            w_max_v  = w_max_upd;
            w_state  = H_SETTLE;
          end
        end
      end

      V_SETTLE: begin
        if (bus.abort) begin
          w_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state = V_SAMPLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      V_SAMPLE: begin
        if (bus.abort) begin
          w_state = IDLE;
        end else if (bus.adc_valid) begin
          w_cnt    = '0;
          w_best_v = w_v_best_upd;
          w_max_v  = w_max_upd;
          if (w_v_last) begin
            w_pos_v = w_v_best_upd;
            w_done  = 1'b1;
            w_state = IDLE;
          end else begin
            w_pos_v = w_v_sum[POS_W-1:0];
            w_state = V_SETTLE;
          end
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers; busy is registered from the next state so it
  // lines up exactly with STAT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_pos_h  <= P_MID;
      r_pos_v  <= P_MID;
      r_best_h <= P_MIN;
      r_best_v <= P_MIN;
      r_max_v  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pos_h  <= w_pos_h;
      r_pos_v  <= w_pos_v;
      r_best_h <= w_best_h;
      r_best_v <= w_best_v;
      r_max_v  <= w_max_v;
      r_cnt    <= w_cnt;
      r_busy   <= (w_state != IDLE);
      r_done   <= w_done;
    end
  end

  assign bus.pos_H    = r_pos_h;
  assign bus.pos_V    = r_pos_v;
  assign bus.max_V_in = r_max_v;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.STAT     = r_state;

endmodule

// File: tb/tb_calib_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calib_scan_ctrl
// Self-checking bench for calib_scan_ctrl with a small scan grid:
// POS_MIN=0, POS_MAX=40, POS_STEP=10, SETTLE_CYCLES=4 (5 points per axis).
// A table of ADC voltage patterns with hand-computed scan results is run in
// a loop; reset, abort, stalled ADC and ignored-request corner cases are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_calib_scan_ctrl;

  localparam int unsigned POS_W = 32;

  logic clk;
  logic rstN;

  int errCount;
  int checkCount;
  int patternMode;

  calib_scan_ctrl_if #(.POS_W(POS_W)) bus ();

  calib_scan_ctrl #(
    .POS_W        (POS_W),
    .POS_MIN      (0),
    .POS_MAX      (40),
    .POS_STEP     (10),
    .SETTLE_CYCLES(4)
  ) dut (
    .CLK(clk),
    .RST(rstN),
    .bus(bus)
  );

  // 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [31:0] expPosH;
    logic [31:0] expPosV;
    logic [31:0] expMax;
    int          expLatency;
  } scanVec_t;

  // Voltage seen by the panel at the current servo position for each pattern.
  function automatic logic [11:0] patternData(input int mode, input logic [2:0] stat,
                                              input logic [31:0] ph, input logic [31:0] pv);
    logic isV;
    isV = (stat == 3'd3) || (stat == 3'd4);
    case (mode)
      0: patternData = isV ? ((pv == 30) ? 12'd700 : 12'd200) : ((ph == 20) ? 12'd900 : 12'd100);
      1: patternData = 12'd500;
      2: patternData = isV ? 12'(100 - pv) : 12'(ph + 1);
      3: patternData = 12'd0;
      4: patternData = isV ? (((pv == 20) || (pv == 40)) ? 12'd300 : 12'd50)
                           : (((ph == 10) || (ph == 30)) ? 12'd300 : 12'd50);
      default: patternData = 12'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock edge, then present the ADC value for the new position.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    bus.adc_data = patternData(patternMode, bus.STAT, bus.pos_H, bus.pos_V);
  endtask

  // Leave any scan and make sure the sequencer is idle.
  task automatic goIdle();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    applyStimulus();
    bus.abort = 1'b0;
    applyStimulus();
  endtask

  // Start a scan and wait (bounded) for done; reports the cycle count from
  // the start edge, and whether done arrived. Optionally pulses start mid-scan.
  task automatic runToDone(input int pulseAt, output int latency, output bit seen);
    seen = 1'b0;
    latency = 0;
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      bus.start = (c == pulseAt);
      applyStimulus();
      if (bus.done === 1'b1) begin
        latency = c;
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until STAT and, optionally, a vertical position match.
  task automatic waitFor(input logic [2:0] stat, input bit usePv, input logic [31:0] pv,
                         input string name);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.STAT == stat && (!usePv || bus.pos_V == pv)) begin
        hit = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput(name, 32'(hit), 32'd1);
  endtask

  scanVec_t vecs[5];

  initial begin
    int  lat;
    bit  seen;
    bit  sawV;
    int  stuck;
    logic [31:0] holdPos;

    // Pattern table: {mode, final pos_H, final pos_V, final max_V_in, latency}.
    vecs[0] = '{0, 32'd20, 32'd30, 32'd700, 50};
    vecs[1] = '{1, 32'd0,  32'd0,  32'd500, 50};
    vecs[2] = '{2, 32'd40, 32'd0,  32'd100, 50};
    vecs[3] = '{3, 32'd0,  32'd0,  32'd0,   50};
    vecs[4] = '{4, 32'd10, 32'd20, 32'd300, 50};

    errCount    = 0;
    checkCount  = 0;
    patternMode = 0;
    rstN          = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data  = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("rst_posH", bus.pos_H, 32'd20);
    checkOutput("rst_posV", bus.pos_V, 32'd20);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_stat", 32'(bus.STAT), 32'd0);
    checkOutput("rst_max", 32'(bus.max_V_in), 32'd0);

    // Start timing: first point settles for exactly 4 cycles.
    $display("[TB] start timing");
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    checkOutput("start_busy", 32'(bus.busy), 32'd1);
    checkOutput("start_stat", 32'(bus.STAT), 32'd1);
    checkOutput("start_posH", bus.pos_H, 32'd0);
    checkOutput("start_posV_held", bus.pos_V, 32'd20);
    repeat (3) applyStimulus();
    checkOutput("settle_stat_e3", 32'(bus.STAT), 32'd1);
    applyStimulus();
    checkOutput("settle_stat_e4", 32'(bus.STAT), 32'd2);

    // Asynchronous reset mid-scan, checked before the next edge.
    $display("[TB] async reset mid-scan");
    repeat (8) applyStimulus();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_posH", bus.pos_H, 32'd20);
    checkOutput("arst_posV", bus.pos_V, 32'd20);
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    checkOutput("arst_done", 32'(bus.done), 32'd0);
    checkOutput("arst_stat", 32'(bus.STAT), 32'd0);
    checkOutput("arst_max", 32'(bus.max_V_in), 32'd0);
    #2;
    rstN = 1'b1;
    applyStimulus();

    // Table-driven full scans with adc_valid held high.
    for (int i = 0; i < 5; i++) begin
      $display("[TB] pattern %0d", vecs[i].mode);
      patternMode = vecs[i].mode;
      sawV = 1'b0;
      lat  = 0;
      seen = 1'b0;
      bus.start = 1'b1;
      applyStimulus();
      bus.start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
        applyStimulus();
        if (!sawV && bus.STAT == 3'd3) begin
          sawV = 1'b1;
          checkOutput("vec_park_posH", bus.pos_H, vecs[i].expPosH);
          checkOutput("vec_park_max", 32'(bus.max_V_in), 32'd0);
          checkOutput("vec_park_posV", bus.pos_V, 32'd0);
        end
        if (bus.done === 1'b1) begin
          lat  = c;
          seen = 1'b1;
          break;
        end
      end
      checkOutput("vec_done_seen", 32'(seen), 32'd1);
      checkOutput("vec_latency", 32'(lat), 32'(vecs[i].expLatency));
      checkOutput("vec_busy_at_done", 32'(bus.busy), 32'd0);
      checkOutput("vec_stat", 32'(bus.STAT), 32'd0);
      checkOutput("vec_posH", bus.pos_H, vecs[i].expPosH);
      checkOutput("vec_posV", bus.pos_V, vecs[i].expPosV);
      checkOutput("vec_max", 32'(bus.max_V_in), vecs[i].expMax);
      applyStimulus();
      checkOutput("vec_done_one_cycle", 32'(bus.done), 32'd0);
    end

    // Withheld adc_valid: the sampler must wait indefinitely.
    $display("[TB] stalled ADC");
    patternMode = 1;
    bus.adc_valid = 1'b0;
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    waitFor(3'd2, 1'b0, 32'd0, "stall_reach_sample");
    holdPos = bus.pos_H;
    stuck = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus();
      if (bus.STAT == 3'd2 && bus.pos_H == holdPos) stuck++;
    end
    checkOutput("stall_cycles_held", 32'(stuck), 32'd100);
    checkOutput("stall_posH", bus.pos_H, 32'd0);
    bus.adc_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      applyStimulus();
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("stall_resume_done", 32'(seen), 32'd1);
    checkOutput("stall_resume_posH", bus.pos_H, 32'd0);
    checkOutput("stall_resume_posV", bus.pos_V, 32'd0);
    checkOutput("stall_resume_max", 32'(bus.max_V_in), 32'd500);
    applyStimulus();

    // Abort at vertical point 3 (pos_V=20) during V_SETTLE.
    $display("[TB] abort in vertical settle");
    patternMode = 0;
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    waitFor(3'd3, 1'b1, 32'd20, "abort_reach_v3");
    bus.abort = 1'b1;
    applyStimulus();
    bus.abort = 1'b0;
    checkOutput("abort_stat", 32'(bus.STAT), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_posH", bus.pos_H, 32'd20);
    checkOutput("abort_posV", bus.pos_V, 32'd20);
    checkOutput("abort_max", 32'(bus.max_V_in), 32'd200);
    stuck = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      if (bus.done !== 1'b0 || bus.pos_V != 32'd20) stuck++;
    end
    checkOutput("abort_quiet_after", 32'(stuck), 32'd0);

    // abort wins over a simultaneous adc_valid in H_SAMPLE.
    $display("[TB] abort versus adc_valid");
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    waitFor(3'd2, 1'b0, 32'd0, "prio_reach_sample");
    bus.abort = 1'b1;
    bus.adc_data = 12'd4000;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    checkOutput("prio_stat", 32'(bus.STAT), 32'd0);
    checkOutput("prio_posH", bus.pos_H, 32'd0);
    checkOutput("prio_max", 32'(bus.max_V_in), 32'd0);
    applyStimulus();

    // start while busy is ignored: the scan finishes on its normal schedule.
    $display("[TB] start while busy");
    patternMode = 0;
    runToDone(7, lat, seen);
    checkOutput("busy_start_seen", 32'(seen), 32'd1);
    checkOutput("busy_start_latency", 32'(lat), 32'd50);
    checkOutput("busy_start_posH", bus.pos_H, 32'd20);
    checkOutput("busy_start_posV", bus.pos_V, 32'd30);

    // start asserted in the done cycle launches a new scan immediately.
    $display("[TB] start during done");
    bus.start = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    checkOutput("restart_busy", 32'(bus.busy), 32'd1);
    checkOutput("restart_stat", 32'(bus.STAT), 32'd1);
    checkOutput("restart_posH", bus.pos_H, 32'd0);
    checkOutput("restart_done", 32'(bus.done), 32'd0);
    goIdle();

    // start and abort together in IDLE: stay idle.
    $display("[TB] start with abort in idle");
    bus.start = 1'b1;
    bus.abort = 1'b1;
    applyStimulus();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("sa_busy", 32'(bus.busy), 32'd0);
    checkOutput("sa_stat", 32'(bus.STAT), 32'd0);
    applyStimulus();
    checkOutput("sa_busy_later", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/calib_scan_ctrl.md
# calib_scan_ctrl

Calibration scan sequencer for the two-axis solar panel tracker. On a start request it steps the horizontal servo position across a configured range, waits for mechanical settling, and samples the panel voltage from the ADC at each step. It parks the horizontal axis at the best point, then repeats the scan on the vertical axis. Its position outputs drive the servo PWM generators' pulse-width inputs; its status feeds the LCD and debug logic.

## Interface
Parameters:
- POS_W, 32, width of servo position (pulse width in CLK cycles)
- POS_MIN, 50000, first scan position (0.5 ms at 100 MHz)
- POS_MAX, 250000, last allowed scan position (2.5 ms)
- POS_STEP, 10000, scan increment; must be > 0
- SETTLE_CYCLES, 1000, settle wait per point; must be ≥ 1

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- start  in  1  scan request; sampled each edge, acted on only in IDLE
- abort  in  1  cancel scan; acted on in any non-IDLE state
- adc_valid  in  1  adc_data holds a fresh conversion this cycle
- adc_data  in  12  panel voltage sample, unsigned
- pos_H  out  POS_W  horizontal servo position
- pos_V  out  POS_W  vertical servo position
- max_V_in  out  12  best voltage found in the most recent axis scan
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse on scan completion
- STAT  out  3  state code

## Operation
- States and STAT codes: IDLE 000, H_SETTLE 001, H_SAMPLE 010, V_SETTLE 011, V_SAMPLE 100.
- IDLE:
  - start=1 and abort=0 → H_SETTLE; pos_H←POS_MIN, max_V_in←0, best_H←POS_MIN, settle counter←0.
  - pos_V is held during the horizontal scan.
- H_SETTLE: counter increments each cycle. After exactly SETTLE_CYCLES cycles in this state → H_SAMPLE. adc_valid is ignored here.
- H_SAMPLE: wait indefinitely for adc_valid. On adc_valid:
  - If adc_data > max_V_in (strict), then max_V_in←adc_data and best_H←pos_H. On ties the earliest position wins.
  - If pos_H+POS_STEP > POS_MAX: pos_H←best_H, pos_V←POS_MIN, max_V_in←0, best_V←POS_MIN, → V_SETTLE.
  - Otherwise: pos_H←pos_H+POS_STEP, → H_SETTLE.
- V_SETTLE / V_SAMPLE: same as the horizontal states, acting on pos_V and best_V. On the final sample: pos_V←best_V, done←1 for one cycle, → IDLE.
- Points per axis: floor((POS_MAX−POS_MIN)/POS_STEP)+1. Defaults give 21.
- The comparison pos+POS_STEP > POS_MAX is computed in POS_W+1 bits, so it never wraps.
- abort in a non-IDLE state → IDLE on the next edge.
  - pos_H and pos_V freeze at their current values.
  - max_V_in is kept; no done pulse.
  - abort has priority over adc_valid in the same cycle.
- start while busy is ignored. start and abort together in IDLE: remain in IDLE.
- Reset values:
  - State IDLE; busy=0, done=0, STAT=000, max_V_in=0.
  - pos_H = pos_V = (POS_MIN+POS_MAX)/2 (150000 with defaults).
  - best_H = best_V = POS_MIN; counter = 0.
- Reset asserted mid-scan returns all outputs to their reset values immediately (asynchronous reset).

## Timing
- All outputs are registered.
- start sampled at edge E0 → after E0: busy=1, STAT=001, pos_H=POS_MIN.
- With adc_valid held high, point k (k=1..N of the combined H+V sequence) is sampled at edge E0+k·(SETTLE_CYCLES+1).
- Position update is visible the cycle after the sampling edge.
- done is high for exactly one cycle, following the last V sample edge; busy falls in the same cycle.
- Total scan latency with valid held high: 2·N·(SETTLE_CYCLES+1) cycles.
- A new start is accepted in the cycle done is high, because the state is IDLE.

## Test plan
Directed tests use POS_MIN=0, POS_MAX=40, POS_STEP=10, SETTLE_CYCLES=4, so 5 points per axis.
1. Reset: pulse RST low mid-run. Required: pos_H=pos_V=20, busy=0, done=0, STAT=000, max_V_in=0, asserted before the next CLK edge.
2. Full scan, adc_valid held high.
   - Stimulus: adc_data = 900 at pos_H=20 and 100 at other H positions; during V scan, 700 at pos_V=30 and 200 elsewhere.
   - Required: done pulses 50 cycles after the start edge; then pos_H=20, pos_V=30, max_V_in=700, STAT=000.
3. Flat input, adc_data=500 always. Required: final pos_H=0, pos_V=0 (earliest point wins ties), max_V_in=500.
4. Withheld adc_valid: hold it low after entering H_SAMPLE for 100 cycles. Required: STAT stays 010 and pos_H is unchanged. Releasing it resumes the scan normally.
5. Abort issued at V point 3 (during V_SETTLE). Required:
   - Next cycle: STAT=000, busy=0, no done.
   - pos_H = best_H from the H scan; pos_V=20.
6. Ignored requests:
   - start pulsed while busy changes nothing.
   - start+abort together in IDLE keeps busy=0.
   - start asserted in the cycle done is high begins a new scan on the next edge.
